secret_accum_core: RTL and testbench

Implementation-side responder for the protected "secret" library interface: the logic that sits behind the protected wrapper and that the DPI-protect test harness drives.
- Holds a registered accumulator that adds a hidden constant each cycle.
- Provides a combinational bypass view of the accumulator.
- Provides zero-latency pass-through lanes of assorted widths, used to exercise marshalling across the protection boundary.
- Adds wrap and activity status for the verification bench.

---
 rtl/secret_accum_core.sv | 93 +++++++++
 tb/tb_secret_accum_core.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secret_accum_core.sv
// secret_accum_core
// Responder that sits behind the protected "secret" library wrapper.
// Holds a registered accumulator that adds a hidden constant every cycle,
// exposes a combinational bypass view of it, and provides a set of
// zero-latency pass-through lanes of assorted widths. These lanes exist
// so that marshalling across the protection boundary can be exercised.
// Wrap and activity status are exported for the verification bench.

module secret_accum_core #(
   parameter int WIDTH        = 32,
   parameter int SECRET_VALUE = 7,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     accum_in,
   output logic [WIDTH-1:0]     accum_out,
   input  logic                 accum_bypass,
   output logic [WIDTH-1:0]     accum_bypass_out,
   output logic                 accum_wrap,
   output logic [CNT_WIDTH-1:0] accum_count,
   input  logic                 s1_in,
   output logic                 s1_out,
   input  logic [1:0]           s2_in,
   output logic [1:0]           s2_out,
   input  logic [7:0]           s8_in,
   output logic [7:0]           s8_out,
   input  logic [32:0]          s33_in,
   output logic [32:0]          s33_out,
   input  logic [63:0]          s64_in,
   output logic [63:0]          s64_out,
   input  logic [64:0]          s65_in,
   output logic [64:0]          s65_out,
   input  logic [128:0]         s129_in,
   output logic [128:0]         s129_out,
   input  logic [3:0][31:0]     s4x32_in,
   output logic [3:0][31:0]     s4x32_out
);

   // The hidden constant is truncated to the accumulator width.
   localparam logic [WIDTH-1:0] SECRET_TRUNC = WIDTH'(SECRET_VALUE);

   // The sum uses two extra bits so that overflow can be detected.
   // Adding two WIDTH-bit values plus a constant can carry into either
   // of those two upper bits.
   logic [WIDTH+1:0] accum_sum;

   // Form the next accumulator value with enough headroom to detect overflow.
   always_comb begin
      accum_sum = {2'b00, accum_out} + {2'b00, accum_in} + {2'b00, SECRET_TRUNC};
   end

   // Accumulator and sticky wrap flag.
   // The accumulator keeps running whether or not bypass is selected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum_out  <= '0;
         accum_wrap <= 1'b0;
      end else begin
         accum_out <= accum_sum[WIDTH-1:0];
         if (accum_sum[WIDTH+1:WIDTH] != 2'b00) begin
            accum_wrap <= 1'b1;
         end
      end
   end

   // Count edges since reset release. The counter saturates at all-ones
   // instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum_count <= '0;
      end else if (accum_count != {CNT_WIDTH{1'b1}}) begin
         accum_count <= accum_count + CNT_WIDTH'(1);
      end
   end

   // Bypass view: this path is purely combinational, so a bypass toggle
   // takes effect within the same cycle.
   always_comb begin
      accum_bypass_out = accum_bypass ? accum_in : accum_out;
   end

   // Pass-through lanes are wired straight across at full width.
   assign s1_out    = s1_in;
   assign s2_out    = s2_in;
   assign s8_out    = s8_in;
   assign s33_out   = s33_in;
   assign s64_out   = s64_in;
   assign s65_out   = s65_in;
   assign s129_out  = s129_in;
   assign s4x32_out = s4x32_in;

endmodule

// File: tb/tb_secret_accum_core.sv
// tb_secret_accum_core
// Directed bench for secret_accum_core. The bench uses two instances:
// one with the default parameters, and a narrow one whose small counter
// and oversized secret make saturation and truncation quick to reach.

module tb_secret_accum_core;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   accum_in = '0;
   logic          accum_bypass = 1'b0;
   logic [31:0]   accum_out;
   logic [31:0]   accum_bypass_out;
   logic          accum_wrap;
   logic [15:0]   accum_count;
   logic          s1_in = '0;
   logic          s1_out;
   logic [1:0]    s2_in = '0;
   logic [1:0]    s2_out;
   logic [7:0]    s8_in = '0;
   logic [7:0]    s8_out;
   logic [32:0]   s33_in = '0;
   logic [32:0]   s33_out;
   logic [63:0]   s64_in = '0;
   logic [63:0]   s64_out;
   logic [64:0]   s65_in = '0;
   logic [64:0]   s65_out;
   logic [128:0]  s129_in = '0;
   logic [128:0]  s129_out;
   logic [3:0][31:0] s4x32_in = '0;
   logic [3:0][31:0] s4x32_out;

   logic [7:0]    sm_in = '0;
   logic [7:0]    sm_out;
   logic [7:0]    sm_bypass_out;
   logic          sm_wrap;
   logic [2:0]    sm_count;
   logic          sm_s1_out;
   logic [1:0]    sm_s2_out;
   logic [7:0]    sm_s8_out;
   logic [32:0]   sm_s33_out;
   logic [63:0]   sm_s64_out;
   logic [64:0]   sm_s65_out;
   logic [128:0]  sm_s129_out;
   logic [3:0][31:0] sm_s4x32_out;

   int checks = 0;
   int failures = 0;

   secret_accum_core dut (
      .clk(clk), .rst(rst),
      .accum_in(accum_in), .accum_out(accum_out),
      .accum_bypass(accum_bypass), .accum_bypass_out(accum_bypass_out),
      .accum_wrap(accum_wrap), .accum_count(accum_count),
      .s1_in(s1_in), .s1_out(s1_out),
      .s2_in(s2_in), .s2_out(s2_out),
      .s8_in(s8_in), .s8_out(s8_out),
      .s33_in(s33_in), .s33_out(s33_out),
      .s64_in(s64_in), .s64_out(s64_out),
      .s65_in(s65_in), .s65_out(s65_out),
      .s129_in(s129_in), .s129_out(s129_out),
      .s4x32_in(s4x32_in), .s4x32_out(s4x32_out)
   );

   // SECRET_VALUE 300 truncates to 8'd44; the 3-bit counter saturates at 7
   secret_accum_core #(.WIDTH(8), .SECRET_VALUE(300), .CNT_WIDTH(3)) dut_small (
      .clk(clk), .rst(rst),
      .accum_in(sm_in), .accum_out(sm_out),
      .accum_bypass(1'b0), .accum_bypass_out(sm_bypass_out),
      .accum_wrap(sm_wrap), .accum_count(sm_count),
      .s1_in(s1_in), .s1_out(sm_s1_out),
      .s2_in(s2_in), .s2_out(sm_s2_out),
      .s8_in(s8_in), .s8_out(sm_s8_out),
      .s33_in(s33_in), .s33_out(sm_s33_out),
      .s64_in(s64_in), .s64_out(sm_s64_out),
      .s65_in(s65_in), .s65_out(sm_s65_out),
      .s129_in(s129_in), .s129_out(sm_s129_out),
      .s4x32_in(s4x32_in), .s4x32_out(sm_s4x32_out)
   );

   always #5 clk = ~clk;

   // Hold reset across one posedge and release it on a negedge, so that
   // the next posedge is the first one counted.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      accum_in = 32'h0000ABCD;
      accum_bypass = 1'b1;
      #1;
      checks++;
      if (accum_out !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_accum: got %0h expected 0", accum_out);
      end
      checks++;
      if (accum_wrap !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_wrap: got %0b expected 0", accum_wrap);
      end
      checks++;
      if (accum_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_count: got %0d expected 0", accum_count);
      end
      checks++;
      if (accum_bypass_out !== 32'h0000ABCD) begin
         failures++;
         $display("[TB] FAIL reset_bypass_on: got %0h expected abcd", accum_bypass_out);
      end
      accum_bypass = 1'b0;
      #1;
      checks++;
      if (accum_bypass_out !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_bypass_off: got %0h expected 0", accum_bypass_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'd0 || accum_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_held_edge: got accum %0h count %0d expected 0 0", accum_out, accum_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_accum_zero();
      logic [31:0] exp_vals [3] = '{32'd7, 32'd14, 32'd21};
      do_reset();
      accum_in = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (accum_out !== exp_vals[i]) begin
            failures++;
            $display("[TB] FAIL accum_zero_%0d: got %0d expected %0d", i, accum_out, exp_vals[i]);
         end
      end
      checks++;
      if (accum_count !== 16'd3) begin
         failures++;
         $display("[TB] FAIL accum_zero_count: got %0d expected 3", accum_count);
      end
      checks++;
      if (accum_wrap !== 1'b0) begin
         failures++;
         $display("[TB] FAIL accum_zero_wrap: got %0b expected 0", accum_wrap);
      end
   endtask

   task automatic test_accum_100();
      logic [31:0] exp_vals [2] = '{32'd107, 32'd214};
      do_reset();
      accum_in = 32'd100;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (accum_out !== exp_vals[i]) begin
            failures++;
            $display("[TB] FAIL accum_100_%0d: got %0d expected %0d", i, accum_out, exp_vals[i]);
         end
         checks++;
         if (accum_bypass_out !== exp_vals[i]) begin
            failures++;
            $display("[TB] FAIL accum_100_view_%0d: got %0d expected %0d", i, accum_bypass_out, exp_vals[i]);
         end
      end
   endtask

   // Continues from 214, the value left by test_accum_100
   task automatic test_bypass();
      @(negedge clk);
      accum_bypass = 1'b1;
      accum_in = 32'h55;
      #1;
      checks++;
      if (accum_bypass_out !== 32'h55) begin
         failures++;
         $display("[TB] FAIL bypass_on: got %0h expected 55", accum_bypass_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'd306) begin
         failures++;
         $display("[TB] FAIL bypass_accum_runs: got %0d expected 306", accum_out);
      end
      checks++;
      if (accum_bypass_out !== 32'h55) begin
         failures++;
         $display("[TB] FAIL bypass_held: got %0h expected 55", accum_bypass_out);
      end
      accum_bypass = 1'b0;
      #1;
      checks++;
      if (accum_bypass_out !== 32'd306) begin
         failures++;
         $display("[TB] FAIL bypass_off: got %0d expected 306", accum_bypass_out);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      accum_in = 32'hFFFFFFF0;
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'hFFFFFFF7 || accum_wrap !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wrap_first: got %0h/%0b expected fffffff7/0", accum_out, accum_wrap);
      end
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'hFFFFFFEE || accum_wrap !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_second: got %0h/%0b expected ffffffee/1", accum_out, accum_wrap);
      end
      @(negedge clk);
      accum_in = 32'd0;
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'hFFFFFFF5 || accum_wrap !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_sticky: got %0h/%0b expected fffffff5/1", accum_out, accum_wrap);
      end
   endtask

   task automatic test_passthrough();
      logic [63:0]  crc;
      logic [511:0] wide;
      crc = 64'h5aef0c8dd70a4497;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wide = {8{crc}};
         s1_in    = wide[0];
         s2_in    = wide[2:1];
         s8_in    = wide[17:10];
         s33_in   = wide[62:30];
         s64_in   = wide[127:64];
         s65_in   = wide[200:136];
         s129_in  = wide[338:210];
         s4x32_in = wide[511:384];
         #1;
         checks++;
         if (s1_out !== wide[0] || s2_out !== wide[2:1] || s8_out !== wide[17:10]) begin
            failures++;
            $display("[TB] FAIL pass_narrow_%0d: got %0h %0h %0h expected %0h %0h %0h",
                     i, s1_out, s2_out, s8_out, wide[0], wide[2:1], wide[17:10]);
         end
         checks++;
         if (s33_out !== wide[62:30] || s64_out !== wide[127:64]) begin
            failures++;
            $display("[TB] FAIL pass_mid_%0d: got %0h %0h expected %0h %0h",
                     i, s33_out, s64_out, wide[62:30], wide[127:64]);
         end
         checks++;
         if (s65_out !== wide[200:136] || s129_out !== wide[338:210]) begin
            failures++;
            $display("[TB] FAIL pass_wide_%0d: got %0h %0h expected %0h %0h",
                     i, s65_out, s129_out, wide[200:136], wide[338:210]);
         end
         checks++;
         if (s4x32_out !== wide[511:384] || s4x32_out[3] !== wide[511:480]) begin
            failures++;
            $display("[TB] FAIL pass_4x32_%0d: got %0h expected %0h", i, s4x32_out, wide[511:384]);
         end
         crc = {crc[62:0], crc[63] ^ crc[2] ^ crc[0]};
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      accum_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'd21) begin
         failures++;
         $display("[TB] FAIL mid_reset_pre: got %0d expected 21", accum_out);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (accum_out !== 32'd0 || accum_wrap !== 1'b0 || accum_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL mid_reset_clear: got %0h/%0b/%0d expected 0/0/0", accum_out, accum_wrap, accum_count);
      end
      @(negedge clk);
      accum_in = 32'd5;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (accum_out !== 32'd12 || accum_count !== 16'd1) begin
         failures++;
         $display("[TB] FAIL mid_reset_release: got %0d count %0d expected 12 count 1", accum_out, accum_count);
      end
   endtask

   // Narrow instance: adds 44 per edge and uses a 3-bit saturating counter
   task automatic test_small_saturate();
      logic [2:0] exp_cnt;
      logic [7:0] exp_acc [9] = '{8'd44, 8'd88, 8'd132, 8'd176, 8'd220, 8'd8, 8'd52, 8'd96, 8'd140};
      do_reset();
      sm_in = 8'd0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         exp_cnt = (i < 7) ? 3'(i + 1) : 3'd7;
         checks++;
         if (sm_count !== exp_cnt) begin
            failures++;
            $display("[TB] FAIL small_count_%0d: got %0d expected %0d", i, sm_count, exp_cnt);
         end
         checks++;
         if (sm_out !== exp_acc[i]) begin
            failures++;
            $display("[TB] FAIL small_accum_%0d: got %0d expected %0d", i, sm_out, exp_acc[i]);
         end
      end
      checks++;
      if (sm_wrap !== 1'b1) begin
         failures++;
         $display("[TB] FAIL small_wrap: got %0b expected 1", sm_wrap);
      end
   endtask

   initial begin
      $display("[TB] starting secret_accum_core bench");
      test_reset();
      test_accum_zero();
      test_accum_100();
      test_bypass();
      test_wrap();
      test_passthrough();
      test_mid_reset();
      test_small_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
